// File: rtl/vga_rect_fill.sv
// rtl/vga_rect_fill.sv - rectangle-fill engine feeding the VGA framebuffer pixel write port
//
// Accepts one fill command (origin, size, 12-bit colour) over a valid/ready
// handshake and emits one pixel write per clock in raster order.
//
// Ports:
//   i_clk, i_reset_n          clock, asynchronous active-low reset
//   i_cmdValid / o_cmdReady   command handshake (ready only in IDLE)
//   i_x0, i_y0, i_w, i_h      rectangle origin and size (0 size = empty fill)
//   i_color                   fill colour {R,G,B} 4 bits each
//   i_abort                   terminate current fill (ignored in IDLE)
//   i_stall                   write port busy; hold the current write
//   o_pxlWe, o_pxlAddr, o_pxlData  pixel write port
//   o_busy                    high while filling or completing
//   o_done                    one-cycle pulse on normal completion
//
// Configuration: define VGA_FILL_CLIP_EN to trim the extent at acceptance so
// that no write ever lands outside SCREEN_W x SCREEN_H. Without it coordinates
// wrap modulo 256 and all w*h writes are issued.

module vga_rect_fill #(
   parameter int          SCREEN_W  = 160,
   parameter int          SCREEN_H  = 120,
   parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_cmdValid,
   output logic        o_cmdReady,
   input  logic [7:0]  i_x0,
   input  logic [7:0]  i_y0,
   input  logic [7:0]  i_w,
   input  logic [7:0]  i_h,
   input  logic [11:0] i_color,
   input  logic        i_abort,
   input  logic        i_stall,
   output logic        o_pxlWe,
   output logic [31:0] o_pxlAddr,
   output logic [31:0] o_pxlData,
   output logic        o_busy,
   output logic        o_done
);

`ifdef VGA_FILL_CLIP_EN
   localparam bit CLIP_EN = 1'b1;
`else
   localparam bit CLIP_EN = 1'b0;
`endif

   localparam logic [8:0] SCR_W = 9'(SCREEN_W);
   localparam logic [8:0] SCR_H = 9'(SCREEN_H);

   typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_DONE} state_t;

   state_t      state_q, state_d;
   logic [7:0]  x_q, x_d, y_q, y_d;
   logic [7:0]  col_q, col_d, row_q, row_d;
   logic [7:0]  x0_q, x0_d, w_q, w_d, h_q, h_d;
   logic [11:0] color_q, color_d;

   // Clipped extent of the incoming command; 9-bit math so a room of
   // SCREEN_W - x0 never wraps.
   logic [8:0]  room_x, room_y;
   logic [7:0]  w_clip, h_clip, w_eff, h_eff;

   assign room_x = SCR_W - {1'b0, i_x0};
   assign room_y = SCR_H - {1'b0, i_y0};

   always_comb begin
      w_clip = i_w;
      if ({1'b0, i_x0} >= SCR_W)
         w_clip = '0;
      else if ({1'b0, i_w} > room_x)
         w_clip = room_x[7:0];
      h_clip = i_h;
      if ({1'b0, i_y0} >= SCR_H)
         h_clip = '0;
      else if ({1'b0, i_h} > room_y)
         h_clip = room_y[7:0];
   end

   assign w_eff = CLIP_EN ? w_clip : i_w;
   assign h_eff = CLIP_EN ? h_clip : i_h;

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      col_d   = col_q;
      row_d   = row_q;
      x0_d    = x0_q;
      w_d     = w_q;
      h_d     = h_q;
      color_d = color_q;
      case (state_q)
         ST_IDLE: begin
            // i_abort is ignored here, even alongside a command.
            if (i_cmdValid) begin
               x0_d    = i_x0;
               w_d     = w_eff;
               h_d     = h_eff;
               color_d = i_color;
               x_d     = i_x0;
               y_d     = i_y0;
               col_d   = '0;
               row_d   = '0;
               state_d = (w_eff == 8'd0 || h_eff == 8'd0) ? ST_DONE : ST_FILL;
            end
         end
         ST_FILL: begin
            if (i_abort) begin
               state_d = ST_IDLE;
            end else if (!i_stall) begin
               if (col_q == w_q - 8'd1) begin
                  col_d = '0;
                  x_d   = x0_q;
                  y_d   = y_q + 8'd1;
                  row_d = row_q + 8'd1;
                  if (row_q == h_q - 8'd1)
                     state_d = ST_DONE;
               end else begin
                  col_d = col_q + 8'd1;
                  x_d   = x_q + 8'd1;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= ST_IDLE;
         x_q     <= '0;
         y_q     <= '0;
         col_q   <= '0;
         row_q   <= '0;
         x0_q    <= '0;
         w_q     <= '0;
         h_q     <= '0;
         color_q <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         col_q   <= col_d;
         row_q   <= row_d;
         x0_q    <= x0_d;
         w_q     <= w_d;
         h_q     <= h_d;
         color_q <= color_d;
      end
   end

   // Address/data come straight from registers; they are forced to zero
   // outside FILL so idle and reset values are clean regardless of ADDR_BASE.
   assign o_pxlWe    = (state_q == ST_FILL);
   assign o_pxlAddr  = o_pxlWe ? (ADDR_BASE | {16'h0, y_q, x_q}) : 32'h0;
   assign o_pxlData  = o_pxlWe ? {20'h0, color_q} : 32'h0;
   assign o_cmdReady = (state_q == ST_IDLE);
   assign o_busy     = (state_q == ST_FILL) || (state_q == ST_DONE);
   // An abort arriving in DONE suppresses the completion pulse.
   assign o_done     = (state_q == ST_DONE) && !i_abort;

endmodule

// File: tb/tb_vga_rect_fill.sv
// tb/tb_vga_rect_fill.sv - randomized self-checking bench for vga_rect_fill

module tb_vga_rect_fill;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid, cmd_ready;
   logic [7:0]  x0_s, y0_s, w_s, h_s;
   logic [11:0] color_s;
   logic        abort_s, stall_s;
   logic        pxl_we, busy, done;
   logic [31:0] pxl_addr, pxl_data;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   vga_rect_fill dut (
      .i_clk      (clk),
      .i_reset_n  (rst_n),
      .i_cmdValid (cmd_valid),
      .o_cmdReady (cmd_ready),
      .i_x0       (x0_s),
      .i_y0       (y0_s),
      .i_w        (w_s),
      .i_h        (h_s),
      .i_color    (color_s),
      .i_abort    (abort_s),
      .i_stall    (stall_s),
      .o_pxlWe    (pxl_we),
      .o_pxlAddr  (pxl_addr),
      .o_pxlData  (pxl_data),
      .o_busy     (busy),
      .o_done     (done)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic randomize_fields();
      x0_s    = 8'($urandom);
      y0_s    = 8'($urandom);
      w_s     = 8'($urandom);
      h_s     = 8'($urandom);
      color_s = 12'($urandom);
   endtask

   // Issues one command and follows it until the engine is ready again.
   // Expected pixel sequence is built up front as a list of raster addresses.
   task automatic do_fill(input logic [7:0] x0, input logic [7:0] y0,
                          input logic [7:0] w, input logic [7:0] h,
                          input logic [11:0] col, input int stall_pct,
                          input int stall_from, input int stall_len,
                          input int abort_at, input bit abort_on_accept);
      logic [31:0] exp_q[$];
      int  we_n, he_n, n_exp, taken, last_take, done_cyc, done_cnt, cyc;
      bit  aborted, exited;
      logic [7:0] ax, ay;
      we_n = int'(w);
      he_n = int'(h);
`ifdef VGA_FILL_CLIP_EN
      if (int'(x0) >= 160) we_n = 0; else if (we_n > 160 - int'(x0)) we_n = 160 - int'(x0);
      if (int'(y0) >= 120) he_n = 0; else if (he_n > 120 - int'(y0)) he_n = 120 - int'(y0);
`endif
      for (int r = 0; r < he_n; r++)
         for (int c = 0; c < we_n; c++) begin
            ax = x0 + 8'(c);
            ay = y0 + 8'(r);
            exp_q.push_back({16'h0, ay, ax});
         end
      n_exp = exp_q.size();

      check_eq("ready_before_cmd", cmd_ready, 1);
      cmd_valid = 1'b1;
      x0_s = x0; y0_s = y0; w_s = w; h_s = h; color_s = col;
      abort_s = abort_on_accept;
      stall_s = 1'b0;
      @(posedge clk); #1;
      abort_s = 1'b0;
      taken = 0; last_take = -1; done_cyc = -1; done_cnt = 0;
      aborted = 1'b0; exited = 1'b0;
      for (cyc = 0; cyc < 5000; cyc++) begin
         // Garbage commands while busy must be ignored.
         cmd_valid = 1'($urandom_range(0, 1));
         randomize_fields();
         stall_s = (int'($urandom_range(0, 99)) < stall_pct) ||
                   (cyc >= stall_from && cyc < stall_from + stall_len);
         abort_s = (cyc == abort_at);
         @(negedge clk);
         if (cmd_ready) begin
            exited = 1'b1;
            break;
         end
         if (abort_s) aborted = 1'b1;
         check_eq("busy", busy, 1);
         if (pxl_we) begin
            if (exp_q.size() == 0) begin
               check_eq("extra_write", pxl_we, 0);
            end else begin
               check_eq("addr", pxl_addr, exp_q[0]);
               check_eq("data", pxl_data, {20'h0, col});
               if (!stall_s) begin
                  void'(exp_q.pop_front());
                  taken++;
                  last_take = cyc;
               end
            end
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         @(posedge clk); #1;
      end
      cmd_valid = 1'b0;
      abort_s   = 1'b0;
      stall_s   = 1'b0;
      if (!exited) check_eq("timeout_ready", cmd_ready, 1);
      check_eq("we_idle", pxl_we, 0);
      check_eq("busy_idle", busy, 0);
      if (aborted) begin
         check_eq("abort_no_done", done_cnt, 0);
         check_eq("abort_ready_cyc", cyc, abort_at + 1);
      end else begin
         check_eq("write_count", taken, n_exp);
         check_eq("done_count", done_cnt, 1);
         check_eq("done_cyc", done_cyc, last_take + 1);
         check_eq("ready_cyc", cyc, done_cyc + 1);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      rst_n = 1'b0;
      cmd_valid = 1'b0; abort_s = 1'b0; stall_s = 1'b0;
      x0_s = '0; y0_s = '0; w_s = '0; h_s = '0; color_s = '0;
      #12;
      check_eq("rst_ready", cmd_ready, 1);
      check_eq("rst_we", pxl_we, 0);
      check_eq("rst_addr", pxl_addr, 0);
      check_eq("rst_data", pxl_data, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      do_fill(8'd10, 8'd5, 8'd3, 8'd2, 12'hF00, 0, -1, 0, -1, 1'b0);
      do_fill(8'd3, 8'd4, 8'd0, 8'd7, 12'h0F0, 0, -1, 0, -1, 1'b0);
      do_fill(8'd10, 8'd5, 8'd3, 8'd2, 12'hF00, 0, 1, 3, -1, 1'b0);
      do_fill(8'd20, 8'd30, 8'd4, 8'd4, 12'h00F, 0, -1, 0, 2, 1'b0);
      do_fill(8'd1, 8'd1, 8'd2, 8'd2, 12'h123, 0, -1, 0, -1, 1'b0);
      do_fill(8'd158, 8'd118, 8'd4, 8'd4, 12'hABC, 0, -1, 0, -1, 1'b0);
      do_fill(8'd250, 8'd254, 8'd9, 8'd3, 12'h456, 20, -1, 0, -1, 1'b0);
      do_fill(8'd40, 8'd50, 8'd5, 8'd1, 12'h789, 0, -1, 0, -1, 1'b1);

      for (int i = 0; i < 40; i++) begin
         do_fill(8'($urandom), 8'($urandom), 8'($urandom_range(0, 12)),
                 8'($urandom_range(0, 12)), 12'($urandom), 25, -1, 0,
                 ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 30)) : -1,
                 1'($urandom_range(0, 1)));
      end

      // Reset in the middle of a fill.
      cmd_valid = 1'b1;
      x0_s = 8'd60; y0_s = 8'd70; w_s = 8'd8; h_s = 8'd8; color_s = 12'hFFF;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check_eq("midrst_we", pxl_we, 0);
      check_eq("midrst_addr", pxl_addr, 0);
      check_eq("midrst_data", pxl_data, 0);
      check_eq("midrst_busy", busy, 0);
      check_eq("midrst_done", done, 0);
      check_eq("midrst_ready", cmd_ready, 1);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      check_eq("postrst_ready", cmd_ready, 1);
      check_eq("postrst_we", pxl_we, 0);
      do_fill(8'd7, 8'd9, 8'd3, 8'd3, 12'h321, 10, -1, 0, -1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
